// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants for the fifo_cola bank feeding arbitro1
// Word layout: [11:10] destination, [9:8] class, [7:0] payload.
package fifo_pkg;

  localparam int DATA_W    = 12;
  localparam int ADDR_W    = 3;
  localparam int DEST_MSB  = 11;
  localparam int DEST_LSB  = 10;
  localparam int CLASS_MSB = 9;
  localparam int CLASS_LSB = 8;
  localparam int NUM_CH    = 4;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array, one write port, one async read port
// The array is cleared on reset so a stale word can never reach fifo_out.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_cola.sv
// rtl/fifo_cola.sv - first-word-fall-through FIFO for one arbitro1 input channel
// Optional peak-occupancy tracking (max_count, clr_max) under FIFO_WATERMARK_EN.
module fifo_cola
  import fifo_pkg::*;
#(
  parameter int DATA_W    = fifo_pkg::DATA_W,
  parameter int ADDR_W    = fifo_pkg::ADDR_W,
  parameter int AF_MARGIN = 2,
  parameter int AE_LEVEL  = 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FIFO_WATERMARK_EN
  input  logic              clr_max,
  output logic [ADDR_W:0]   max_count,
`endif
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] fifo_in,
  output logic [DATA_W-1:0] fifo_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_error,
  output logic [ADDR_W:0]   count
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic [DATA_W-1:0] rd_data;
  logic              push_ok;
  logic              pop_ok;

  // Flags come from the occupancy register only; pointers wrap freely.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_error <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count_next;
      fifo_error <= (push & ~push_ok) | (pop & empty);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (fifo_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign fifo_out = empty ? '0 : rd_data;

`ifdef FIFO_WATERMARK_EN
  // A clear snaps the peak to the present occupancy rather than zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_count <= '0;
    end else if (clr_max) begin
      max_count <= count;
    end else if (count_next > max_count) begin
      max_count <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_cola.sv
// tb/tb_fifo_cola.sv - table-driven and scoreboard testbench for fifo_cola
// Build with +define+FIFO_WATERMARK_EN to also check max_count.
module tb_fifo_cola;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [11:0] fifo_in = '0;
  logic [11:0] fifo_out;
  logic        empty, full, almost_full, almost_empty, fifo_error;
  logic [3:0]  count;
`ifdef FIFO_WATERMARK_EN
  logic        clr_max = 1'b0;
  logic [3:0]  max_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          p;
    bit          q;
    logic [11:0] din;
    bit          err;
    int          cnt;
    logic [11:0] out;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  fifo_cola dut (
    .clk          (clk),
    .reset        (reset),
`ifdef FIFO_WATERMARK_EN
    .clr_max      (clr_max),
    .max_count    (max_count),
`endif
    .push         (push),
    .pop          (pop),
    .fifo_in      (fifo_in),
    .fifo_out     (fifo_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error),
    .count        (count)
  );

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  function automatic void add(bit p, bit q, logic [11:0] d, bit e, int c, logic [11:0] o);
    vec_t v;
    v.p = p; v.q = q; v.din = d; v.err = e; v.cnt = c; v.out = o;
    vecs.push_back(v);
  endfunction

  // One clock with the given request; the scoreboard compares the head word on every accepted pop.
  task automatic cyc(bit p, bit q, logic [11:0] d);
    logic [11:0] head;
    logic [11:0] want;
    bit          pop_acc;
    bit          push_acc;
    push = p; pop = q; fifo_in = d;
    #1;
    head     = fifo_out;
    pop_acc  = q && (sb.size() > 0);
    push_acc = p && ((sb.size() < 8) || pop_acc);
    @(posedge clk);
    if (pop_acc) begin
      want = sb.pop_front();
      chk("sb_data", -1, 32'(head), 32'(want));
    end
    if (push_acc) sb.push_back(d);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic chk_state(string tag, int row, int c, logic [11:0] o, bit e);
    chk({tag, "_err"},   row, 32'(fifo_error),   32'(e));
    chk({tag, "_count"}, row, 32'(count),        32'(c));
    chk({tag, "_out"},   row, 32'(fifo_out),     32'(o));
    chk({tag, "_empty"}, row, 32'(empty),        32'(c == 0));
    chk({tag, "_full"},  row, 32'(full),         32'(c == 8));
    chk({tag, "_af"},    row, 32'(almost_full),  32'(c >= 6));
    chk({tag, "_ae"},    row, 32'(almost_empty), 32'(c <= 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    add(1, 0, 12'b000010010110, 0, 1, 12'b000010010110);
    add(0, 0, 12'h000,          0, 1, 12'b000010010110);
    add(0, 1, 12'h000,          0, 0, 12'h000);
    for (int i = 0; i < 8; i++) add(1, 0, 12'(12'h100 + i), 0, i + 1, 12'h100);
    add(1, 0, 12'h123, 1, 8, 12'h100);
    add(0, 0, 12'h000, 0, 8, 12'h100);
    for (int i = 0; i < 8; i++) add(0, 1, 12'h000, 0, 7 - i, (i < 7) ? 12'(12'h101 + i) : 12'h000);
    for (int i = 0; i < 8; i++) add(1, 0, 12'(12'h100 + i), 0, i + 1, 12'h100);
    add(1, 1, 12'h1FF, 0, 8, 12'h101);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 12'h000, 0, 8 - k, (k <= 6) ? 12'(12'h101 + k) : ((k == 7) ? 12'h1FF : 12'h000));
    add(0, 1, 12'h000, 1, 0, 12'h000);
    add(0, 0, 12'h000, 0, 0, 12'h000);
    add(1, 1, 12'h2A5, 1, 1, 12'h2A5);
    add(0, 1, 12'h000, 0, 0, 12'h000);

    repeat (2) @(posedge clk);
    #1;
    chk_state("in_reset", -1, 0, 12'h000, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_state("idle", -1, 0, 12'h000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].p, vecs[i].q, vecs[i].din);
      chk_state("vec", i, vecs[i].cnt, vecs[i].out, vecs[i].err);
    end

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
`ifdef FIFO_WATERMARK_EN
    chk("max_after_pulse", -1, 32'(max_count), 32'(0));
`endif

    for (int i = 0; i < 5; i++) cyc(1, 0, 12'(12'h300 + i));
    chk_state("fill5", -1, 5, 12'h300, 0);
`ifdef FIFO_WATERMARK_EN
    chk("max_before_reset", -1, 32'(max_count), 32'(5));
`endif
    #2;
    reset = 1'b1;
    #1;
    chk_state("async_reset", -1, 0, 12'h000, 0);
`ifdef FIFO_WATERMARK_EN
    chk("max_after_reset", -1, 32'(max_count), 32'(0));
`endif
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 0, 12'h3AB);
    chk_state("post_reset", -1, 1, 12'h3AB, 0);
    cyc(0, 1, 12'h000);
    chk_state("post_drain", -1, 0, 12'h000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_cola.md
Name: fifo_cola

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO that buffers 12-bit words.
- Four instances form the bank that feeds arbitro1.
- Each instance supplies one bit of arbitro1's empty[3:0] and almost_full[3:0] buses, and its fifo_out data.
- arbitro1's push[i]/pop[i] outputs drive the matching instance's push/pop inputs.
- Word format is [11:10] destination, [9:8] class, [7:0] payload; the FIFO does not interpret it.

Parameters:
- DATA_W, 12, word width.
- ADDR_W, 3, pointer width; depth DEPTH = 2**ADDR_W = 8.
- AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN (6).
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- push  in  1  write request; fifo_in is written when accepted.
- pop  in  1  read request; retires the head word.
- fifo_in  in  DATA_W  write data.
- fifo_out  out  DATA_W  head word (FWFT); 0 when empty.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.
- almost_empty  out  1  count <= AE_LEVEL.
- fifo_error  out  1  one-cycle pulse on an illegal request.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.

Behaviour:
- State: mem[DEPTH], wr_ptr, rd_ptr (ADDR_W bits, natural wrap DEPTH-1 -> 0), count register.
- Reset (async assert, sync release): pointers 0, count 0, fifo_error 0, all mem entries 0.
  - Outputs during reset: fifo_out=0, empty=1, almost_empty=1, full=0, almost_full=0, count=0.
  - Reset mid-operation discards all contents immediately; no drain.
- Accept rules, evaluated each posedge:
  - push_ok = push & (~full | pop_ok).
  - pop_ok = pop & ~empty.
- Accepted push: mem[wr_ptr] <= fifo_in; wr_ptr++.
- Accepted pop: rd_ptr++.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Output timing:
  - fifo_out = empty ? 0 : mem[rd_ptr], combinational from registers.
  - A word pushed into an empty FIFO appears on fifo_out the cycle after the push edge; write-to-read latency is 1 cycle.
  - All flags are decoded from the registered count, valid 1 cycle after the causing edge.
- Simultaneous events:
  - Push+pop while full: both accepted, count stays DEPTH, no error.
  - Push+pop while empty: push accepted, pop rejected, fifo_error pulses, count becomes 1.
  - Push+pop at 0<count<DEPTH: both accepted; pointers advance; same-address write/read impossible since count>0.
- Errors:
  - fifo_error <= (push & ~push_ok) | (pop & empty), registered, high for exactly 1 cycle per offending edge.
  - A rejected push leaves mem and pointers unchanged (word dropped).
- Wrap-around: pointers wrap silently; full/empty come from count, never from pointer comparison.
- Back-pressure contract: upstream honours almost_full with a 2-entry margin. arbitro1 may issue up to 2 pushes after seeing almost_full without loss.

Optional Feature:
- Macro: FIFO_WATERMARK_EN.
- Defined:
  - Adds output max_count [ADDR_W:0] holding the peak count since reset.
  - Updates max_count <= max(max_count, next count) each cycle.
  - Reset to 0.
  - Adds input clr_max: sync clear to the current count, with priority over the update.
- Undefined: neither port exists; no extra registers; otherwise identical behaviour.

Decomposition:
- Package fifo_pkg:
  - DATA_W=12, default ADDR_W.
  - Field constants DEST_MSB=11, DEST_LSB=10, CLASS_MSB=9, CLASS_LSB=8.
  - NUM_CH=4, shared by arbitro1 and its tester.
- One sub-module, fifo_mem: DEPTH x DATA_W register array with one write port and one async read port.
  - Async reset clears the array.
- Pointer/count/flag logic stays in fifo_cola.

Test Plan:
- Reset, then idle → empty=1, almost_empty=1, fifo_out=12'h000, count=0, fifo_error=0.
- Push 12'b000010010110 once, no pop.
  - Next cycle: empty=0, fifo_out=12'b000010010110, count=1.
  - Pop on the following edge → empty=1, fifo_out=0.
- Push 8 words 12'h100..12'h107.
  - almost_full rises after the 6th edge; full=1 after the 8th.
  - A 9th push alone → fifo_error pulses 1 cycle, count stays 8.
  - Drain → 12'h100..12'h107 in order.
- With count=8: push 12'h1FF + pop same edge → no error, count=8, fifo_out=12'h101.
  - Drain; last word is 12'h1FF.
- On empty: pop alone → fifo_error pulses.
  - Push+pop same edge → fifo_error pulses, count=1, fifo_out=pushed word.
- Fill to 5, assert reset mid-cycle (asynchronously) → outputs clear before the next posedge.
  - With FIFO_WATERMARK_EN: max_count=5 before the reset, 0 after.
